// File: rtl/channel_buffer_pkg.sv
// Flit field split and handshake FSM encoding shared by the source, channel_buffer, router and sink.
// A flit is {payload, destination}, with the destination in the low bits.
`ifndef CHANNEL_BUFFER_PKG_SV
`define CHANNEL_BUFFER_PKG_SV

`define FLIT_DEST(flit) ((flit)[channel_buffer_pkg::DESTINATION_BITS-1:0])
`define FLIT_PAYLOAD(flit, size) ((flit)[(size)-1:channel_buffer_pkg::DESTINATION_BITS])

package channel_buffer_pkg;

    localparam int DESTINATION_BITS = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic int flit_payload_bits(input int size);
        return size - DESTINATION_BITS;
    endfunction

endpackage

`endif

// File: rtl/channel_buffer_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count and a combinational read port.
// Push is ignored when full and pop is ignored when empty.
module channel_buffer_sync_fifo #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [SIZE-1:0]          wdata,
    output logic [SIZE-1:0]          rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);

    logic [SIZE-1:0]      r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign full      = (r_count == FULL_COUNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (ADDR_BITS+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/channel_buffer.sv
// Two-phase (toggle) req/ack buffer: flits accepted upstream are queued in a FIFO and
// re-issued in order downstream, one in flight at a time.
module channel_buffer
    import channel_buffer_pkg::*;
#(
    parameter int ID    = 0,
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_in,
    input  logic [SIZE-1:0]        data_in,
    output logic                   ack_in,
    output logic                   req_out,
    output logic [SIZE-1:0]        data_out,
    input  logic                   ack_out,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output state_t                 o_dbg_state,
    output logic [31:0]            o_dbg_id
);
    logic            r_req_seen;
    logic            r_ack_in;
    logic            r_req_out;
    logic            r_ack_out_old;
    logic [SIZE-1:0] r_data_out;
    state_t          r_state;
    state_t          w_state_next;
    logic            w_pending;
    logic            w_push;
    logic            w_pop;
    logic            w_ack_received;
    logic            w_full;
    logic            w_empty;
    logic [SIZE-1:0] w_rdata;

    channel_buffer_sync_fifo #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (data_in),
        .rdata (w_rdata),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    // A pending flit while full simply stays unacknowledged until space frees.
    assign w_pending      = req_in ^ r_req_seen;
    assign w_push         = w_pending & ~w_full;
    assign w_ack_received = ack_out ^ r_ack_out_old;

    assign ack_in      = r_ack_in;
    assign req_out     = r_req_out;
    assign data_out    = r_data_out;
    assign full        = w_full;
    assign o_dbg_state = r_state;
    assign o_dbg_id    = 32'(ID);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_next = ST_WAIT;
                    w_pop        = 1'b1;
                end
            end
            ST_WAIT: begin
                if (w_ack_received) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // ack_out_old tracks ack_out in every state so an ack toggle seen while idle is absorbed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_seen    <= 1'b0;
            r_ack_in      <= 1'b0;
            r_req_out     <= 1'b0;
            r_ack_out_old <= 1'b0;
            r_data_out    <= '0;
        end else begin
            r_ack_out_old <= ack_out;
            if (w_push) begin
                r_req_seen <= req_in;
                r_ack_in   <= ~r_ack_in;
            end
            if (w_pop) begin
                r_data_out <= w_rdata;
                r_req_out  <= ~r_req_out;
            end
        end
    end

endmodule

// File: tb/tb_channel_buffer.sv
// Directed bench for channel_buffer: toggle-handshake latency, fill and hold,
// ordering, push/launch overlap, mid-run reset and a spurious downstream ack.
module tb_channel_buffer;
    import channel_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_in;
    logic [7:0]  data_in;
    logic        ack_in;
    logic        req_out;
    logic [7:0]  data_out;
    logic        ack_out;
    logic [2:0]  count;
    logic        full;
    state_t      dbg_state;
    logic [31:0] dbg_id;

    int n_vec = 0;
    int n_err = 0;
    int timeouts = 0;
    int ack_toggles = 0;
    int req_toggles = 0;
    logic seen_ack_in = 1'b0;
    logic seen_req_out = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    channel_buffer #(
        .ID    (0),
        .SIZE  (8),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_in      (req_in),
        .data_in     (data_in),
        .ack_in      (ack_in),
        .req_out     (req_out),
        .data_out    (data_out),
        .ack_out     (ack_out),
        .count       (count),
        .full        (full),
        .o_dbg_state (dbg_state),
        .o_dbg_id    (dbg_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ack_in(input int limit, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            tick();
            if (ack_in !== seen_ack_in) begin
                seen_ack_in = ack_in;
                ack_toggles++;
                ok = 1'b1;
                return;
            end
        end
        timeouts++;
    endtask

    task automatic wait_req_out(input int limit, output logic ok);
        ok = 1'b0;
        for (int c = 0; c <= limit; c++) begin
            if (c != 0) tick();
            if (req_out !== seen_req_out) begin
                seen_req_out = req_out;
                req_toggles++;
                ok = 1'b1;
                return;
            end
        end
        timeouts++;
    endtask

    task automatic send_flits(input logic [7:0] first, input int n);
        logic ok;
        for (int i = 0; i < n; i++) begin
            data_in = first + 8'(i);
            req_in  = ~req_in;
            exp_q.push_back(data_in);
            wait_ack_in(40, ok);
            if (!ok) return;
        end
    endtask

    task automatic recv_flits(input int n, input int max_delay);
        logic ok;
        for (int i = 0; i < n; i++) begin
            wait_req_out(40, ok);
            if (!ok) return;
            obs_q.push_back(data_out);
            repeat ($urandom_range(0, max_delay)) tick();
            ack_out = ~ack_out;
        end
    endtask

    task automatic single_flit(input logic [7:0] d);
        data_in = d;
        req_in  = ~req_in;
        tick();
        n_vec++;
        if (ack_in !== ~seen_ack_in) begin
            n_err++; $display("FAIL single_ack_in: got %b expected %b", ack_in, ~seen_ack_in);
        end
        n_vec++;
        if (req_out !== seen_req_out || count !== 3'd1) begin
            n_err++; $display("FAIL single_stage1: req_out %b count %0d expected req_out %b count 1", req_out, count, seen_req_out);
        end
        seen_ack_in = ~seen_ack_in;
        tick();
        n_vec++;
        if (req_out !== ~seen_req_out || data_out !== d) begin
            n_err++; $display("FAIL single_launch: req_out %b data %h expected req_out %b data %h", req_out, data_out, ~seen_req_out, d);
        end
        n_vec++;
        if (count !== 3'd0 || dbg_state !== ST_WAIT) begin
            n_err++; $display("FAIL single_wait: count %0d state %0d expected count 0 state WAIT", count, dbg_state);
        end
        seen_req_out = ~seen_req_out;
        ack_out = ~ack_out;
        tick();
        n_vec++;
        if (dbg_state !== ST_IDLE || count !== 3'd0) begin
            n_err++; $display("FAIL single_done: state %0d count %0d expected IDLE count 0", dbg_state, count);
        end
    endtask

    task automatic compare_queues(input string name);
        n_vec++;
        if (obs_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL %s_len: got %0d flits expected %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL %s_data[%0d]: got %h expected %h", name, i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_in = 1'b0; ack_out = 1'b0; data_in = 8'h00;
        repeat (2) tick();
        n_vec++;
        if (ack_in !== 1'b0 || req_out !== 1'b0 || data_out !== 8'h00 || count !== 3'd0 || full !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_err++; $display("FAIL reset_values: ack_in %b req_out %b data %h count %0d full %b expected all zero", ack_in, req_out, data_out, count, full);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        single_flit(8'h35);
    endtask

    task automatic test_burst_fill();
        logic ok;
        exp_q.delete(); obs_q.delete(); ack_toggles = 0; timeouts = 0;
        send_flits(8'h01, 5);
        n_vec++;
        if (ack_toggles !== 5 || count !== 3'd4 || full !== 1'b1) begin
            n_err++; $display("FAIL burst_fill: ack toggles %0d count %0d full %b expected 5 4 1", ack_toggles, count, full);
        end
        n_vec++;
        if (req_out !== ~seen_req_out || data_out !== 8'h01 || dbg_state !== ST_WAIT) begin
            n_err++; $display("FAIL burst_inflight: req_out %b data %h expected req_out %b data 01", req_out, data_out, ~seen_req_out);
        end
        seen_req_out = ~seen_req_out;
        obs_q.push_back(data_out);
        data_in = 8'h06; req_in = ~req_in; exp_q.push_back(8'h06);
        repeat (3) tick();
        n_vec++;
        if (ack_in !== seen_ack_in || count !== 3'd4 || full !== 1'b1) begin
            n_err++; $display("FAIL burst_hold: ack_in %b count %0d full %b expected %b 4 1", ack_in, count, full, seen_ack_in);
        end
        ack_out = ~ack_out;
        wait_ack_in(3, ok);
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL burst_release: ack_in %b expected %b within 3 edges", ack_in, ~seen_ack_in);
        end
        recv_flits(5, 0);
        repeat (2) tick();
        compare_queues("burst");
        n_vec++;
        if (count !== 3'd0 || dbg_state !== ST_IDLE || timeouts !== 0) begin
            n_err++; $display("FAIL burst_drain: count %0d state %0d timeouts %0d expected 0 IDLE 0", count, dbg_state, timeouts);
        end
    endtask

    task automatic test_ordering();
        exp_q.delete(); obs_q.delete(); ack_toggles = 0; req_toggles = 0; timeouts = 0;
        fork
            send_flits(8'h80, 50);
            recv_flits(50, 5);
        join
        repeat (2) tick();
        compare_queues("order");
        n_vec++;
        if (ack_toggles !== 50 || req_toggles !== 50 || timeouts !== 0) begin
            n_err++; $display("FAIL order_toggles: ack %0d req %0d timeouts %0d expected 50 50 0", ack_toggles, req_toggles, timeouts);
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        exp_q.delete(); obs_q.delete(); timeouts = 0;
        send_flits(8'h41, 3);
        n_vec++;
        if (count !== 3'd2 || dbg_state !== ST_WAIT) begin
            n_err++; $display("FAIL b2b_setup: count %0d state %0d expected 2 WAIT", count, dbg_state);
        end
        wait_req_out(0, ok);
        obs_q.push_back(data_out);
        ack_out = ~ack_out;
        tick();
        n_vec++;
        if (count !== 3'd2 || dbg_state !== ST_IDLE) begin
            n_err++; $display("FAIL b2b_idle: count %0d state %0d expected 2 IDLE", count, dbg_state);
        end
        data_in = 8'h44; req_in = ~req_in; exp_q.push_back(8'h44);
        tick();
        n_vec++;
        if (count !== 3'd2 || ack_in !== ~seen_ack_in || req_out !== ~seen_req_out || data_out !== 8'h42) begin
            n_err++; $display("FAIL b2b_overlap: count %0d ack_in %b req_out %b data %h expected 2 %b %b 42", count, ack_in, req_out, data_out, ~seen_ack_in, ~seen_req_out);
        end
        seen_ack_in = ~seen_ack_in;
        fork
            send_flits(8'h45, 5);
            recv_flits(8, 2);
        join
        repeat (2) tick();
        compare_queues("wrap");
        n_vec++;
        if (count !== 3'd0 || timeouts !== 0) begin
            n_err++; $display("FAIL wrap_drain: count %0d timeouts %0d expected 0 0", count, timeouts);
        end
    endtask

    task automatic test_reset_mid();
        exp_q.delete();
        send_flits(8'h51, 5);
        n_vec++;
        if (full !== 1'b1 || dbg_state !== ST_WAIT) begin
            n_err++; $display("FAIL rst_pre: full %b state %0d expected 1 WAIT", full, dbg_state);
        end
        reset = 1'b1; req_in = 1'b0; ack_out = 1'b0;
        #1;
        n_vec++;
        if (ack_in !== 1'b0 || req_out !== 1'b0 || data_out !== 8'h00 || count !== 3'd0 || full !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_err++; $display("FAIL rst_mid: ack_in %b req_out %b data %h count %0d full %b expected all zero", ack_in, req_out, data_out, count, full);
        end
        seen_ack_in = 1'b0; seen_req_out = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        single_flit(8'hA0);
    endtask

    task automatic test_spurious_ack();
        ack_out = ~ack_out;
        repeat (2) tick();
        n_vec++;
        if (dbg_state !== ST_IDLE || count !== 3'd0 || req_out !== seen_req_out || ack_in !== seen_ack_in) begin
            n_err++; $display("FAIL spurious_idle: state %0d count %0d req_out %b ack_in %b expected IDLE 0 %b %b", dbg_state, count, req_out, ack_in, seen_req_out, seen_ack_in);
        end
        data_in = 8'h66; req_in = ~req_in;
        repeat (2) tick();
        n_vec++;
        if (req_out !== ~seen_req_out || data_out !== 8'h66 || dbg_state !== ST_WAIT) begin
            n_err++; $display("FAIL spurious_launch: req_out %b data %h state %0d expected %b 66 WAIT", req_out, data_out, dbg_state, ~seen_req_out);
        end
        seen_req_out = ~seen_req_out;
        seen_ack_in = ~seen_ack_in;
        repeat (3) tick();
        n_vec++;
        if (dbg_state !== ST_WAIT) begin
            n_err++; $display("FAIL spurious_hold: state %0d expected WAIT", dbg_state);
        end
        ack_out = ~ack_out;
        tick();
        n_vec++;
        if (dbg_state !== ST_IDLE || count !== 3'd0) begin
            n_err++; $display("FAIL spurious_done: state %0d count %0d expected IDLE 0", dbg_state, count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_fill();
        test_ordering();
        test_back_to_back();
        test_reset_mid();
        test_spurious_ack();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
